// File: rtl/symbol_aligner_10b_if.sv
// Bit-stream input and aligned-symbol output bundle of the 10-bit symbol aligner.
// The master side supplies serial bits and consumes symbols; the slave side is the aligner.
interface symbol_aligner_10b_if;
    logic       bit_i;
    logic       bit_valid_i;
    logic [9:0] data_o;
    logic       valid_o;
    logic       comma_o;
    logic       locked_o;

    modport master (
        output bit_i,
        output bit_valid_i,
        input  data_o,
        input  valid_o,
        input  comma_o,
        input  locked_o
    );

    modport slave (
        input  bit_i,
        input  bit_valid_i,
        output data_o,
        output valid_o,
        output comma_o,
        output locked_o
    );
endinterface

// File: rtl/symbol_aligner_10b.sv
// Serial-to-parallel 8b/10b front end: finds K28.5 symbol boundaries in a recovered bit stream
// and presents aligned 10-bit symbols (first received bit in data_o[9]) with lock status.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_HUNT   | no alignment; waiting for any comma to set the symbol boundary
// ST_CHECK  | tentative alignment; counting aligned commas towards lock
// ST_LOCKED | alignment trusted; misaligned commas counted towards loss
module symbol_aligner_10b #(
    parameter int LOCK_COMMAS = 3,
    parameter int LOSS_COMMAS = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 enable_i,
    symbol_aligner_10b_if.slave  sym_if
);

    localparam int GW = (LOCK_COMMAS > 1) ? $clog2(LOCK_COMMAS + 1) : 1;
    localparam int BW = (LOSS_COMMAS > 1) ? $clog2(LOSS_COMMAS + 1) : 1;

    localparam logic [GW-1:0] GOOD_MAX  = GW'(LOCK_COMMAS);
    localparam logic [BW-1:0] BAD_MAX   = BW'(LOSS_COMMAS);
    localparam logic [GW-1:0] GOOD_ONE  = GW'(1);
    localparam logic [BW-1:0] BAD_ONE   = BW'(1);
    localparam logic [9:0]    K28_5_NEG = 10'b0011111010;
    localparam logic [9:0]    K28_5_POS = 10'b1100000101;
    localparam logic [3:0]    CNT_LAST  = 4'd9;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    sh_q, sh_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [GW-1:0] good_q, good_d;
    logic [BW-1:0] bad_q, bad_d;
    logic [9:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          comma_q, comma_d;
    logic          locked_q, locked_d;

    logic [9:0]    win;
    logic          accept;
    logic          is_comma;
    logic          boundary;
    logic [3:0]    cnt_adv;
    logic [GW-1:0] good_inc;
    logic [BW-1:0] bad_inc;

    always_comb begin
        win      = {sh_q[8:0], sym_if.bit_i};
        accept   = enable_i & sym_if.bit_valid_i;
        is_comma = accept & ((win == K28_5_NEG) | (win == K28_5_POS));
        boundary = (cnt_q == CNT_LAST);
        cnt_adv  = boundary ? 4'd0 : cnt_q + 4'd1;
        good_inc = (good_q == GOOD_MAX) ? good_q : good_q + GOOD_ONE;
        bad_inc  = (bad_q == BAD_MAX) ? bad_q : bad_q + BAD_ONE;

        state_d  = state_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        good_d   = good_q;
        bad_d    = bad_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        comma_d  = 1'b0;

        if (!enable_i) begin
            state_d = ST_HUNT;
            cnt_d   = '0;
            good_d  = '0;
            bad_d   = '0;
        end else if (accept) begin
            sh_d = win;
            unique case (state_q)
                ST_HUNT: begin
                    if (is_comma) begin
                        valid_d = 1'b1;
                        comma_d = 1'b1;
                        data_d  = win;
                        cnt_d   = '0;
                        good_d  = GOOD_ONE;
                        state_d = (LOCK_COMMAS == 1) ? ST_LOCKED : ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (is_comma && !boundary) begin
                        // Trust the newest comma over the tentative boundary.
                        valid_d = 1'b1;
                        comma_d = 1'b1;
                        data_d  = win;
                        cnt_d   = '0;
                        good_d  = GOOD_ONE;
                    end else begin
                        cnt_d = cnt_adv;
                        if (boundary) begin
                            valid_d = 1'b1;
                            comma_d = is_comma;
                            data_d  = win;
                            if (is_comma) begin
                                good_d = good_inc;
                                if (good_inc == GOOD_MAX) begin
                                    state_d = ST_LOCKED;
                                end
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    cnt_d = cnt_adv;
                    if (is_comma && !boundary) begin
                        // A lone stray comma must not move a trusted boundary.
                        bad_d = bad_inc;
                        if (bad_inc == BAD_MAX) begin
                            state_d = ST_HUNT;
                            cnt_d   = '0;
                            bad_d   = '0;
                            good_d  = '0;
                        end
                    end else if (boundary) begin
                        valid_d = 1'b1;
                        comma_d = is_comma;
                        data_d  = win;
                        if (is_comma) begin
                            bad_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    cnt_d   = '0;
                    good_d  = '0;
                    bad_d   = '0;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= ST_HUNT;
            sh_q     <= '0;
            cnt_q    <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            comma_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            comma_q  <= comma_d;
            locked_q <= locked_d;
        end
    end

    assign sym_if.data_o   = data_q;
    assign sym_if.valid_o  = valid_q;
    assign sym_if.comma_o  = comma_q;
    assign sym_if.locked_o = locked_q;

endmodule

// File: tb/tb_symbol_aligner_10b.sv
// Scoreboard bench for symbol_aligner_10b: one instance with default parameters and one with
// LOCK_COMMAS=1/LOSS_COMMAS=1, both fed the same randomized stream and checked against a bit-level model.
module tb_symbol_aligner_10b;

    localparam int K_NEG  = 10'b0011111010;
    localparam int K_POS  = 10'b1100000101;
    localparam int D21_5  = 10'b1010101010;
    localparam int M_HUNT = 0;
    localparam int M_CHK  = 1;
    localparam int M_LOCK = 2;

    typedef struct packed {
        logic [9:0] d;
        logic       c;
        logic       l;
    } exp_t;

    logic clk;
    logic reset_n;
    logic enable;

    symbol_aligner_10b_if u_if0 ();
    symbol_aligner_10b_if u_if1 ();

    symbol_aligner_10b #(.LOCK_COMMAS(3), .LOSS_COMMAS(2)) u_dut0 (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .enable_i  (enable),
        .sym_if    (u_if0.slave)
    );

    symbol_aligner_10b #(.LOCK_COMMAS(1), .LOSS_COMMAS(1)) u_dut1 (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .enable_i  (enable),
        .sym_if    (u_if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    exp_t q0[$];
    exp_t q1[$];

    int lockn[2] = '{3, 1};
    int lossn[2] = '{2, 1};
    int m_hist[2];
    int m_n[2];
    int m_anchor[2];
    int m_good[2];
    int m_bad[2];
    int m_mode[2];
    bit gap_mode = 1'b0;
    bit kpol = 1'b0;

    task automatic chk(string nm, int act, int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s got=0x%0h want=0x%0h", nm, act, req);
        end
    endtask

    task automatic push(int i, int d, bit c, bit l);
        exp_t e;
        e.d = d[9:0];
        e.c = c;
        e.l = l;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_hist[i] = 0; m_n[i] = 0; m_anchor[i] = 0;
            m_good[i] = 0; m_bad[i] = 0; m_mode[i] = M_HUNT;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic model_disable(int i);
        m_mode[i] = M_HUNT;
        m_good[i] = 0;
        m_bad[i]  = 0;
    endtask

    // One accepted bit: symbol boundaries sit every 10 bits after the last anchoring comma.
    task automatic model_bit(int i, bit b);
        bit comma, bnd;
        m_n[i]++;
        m_hist[i] = ((m_hist[i] << 1) | int'(b)) & 1023;
        comma = (m_hist[i] == K_NEG) || (m_hist[i] == K_POS);
        bnd   = ((m_n[i] - m_anchor[i]) % 10) == 0;
        case (m_mode[i])
            M_HUNT: if (comma) begin
                m_anchor[i] = m_n[i];
                m_good[i]   = 1;
                m_mode[i]   = (lockn[i] <= 1) ? M_LOCK : M_CHK;
                push(i, m_hist[i], 1'b1, m_mode[i] == M_LOCK);
            end
            M_CHK: begin
                if (comma && !bnd) begin
                    m_anchor[i] = m_n[i];
                    m_good[i]   = 1;
                    push(i, m_hist[i], 1'b1, 1'b0);
                end else if (bnd) begin
                    if (comma) begin
                        m_good[i]++;
                        if (m_good[i] >= lockn[i]) m_mode[i] = M_LOCK;
                    end
                    push(i, m_hist[i], comma, m_mode[i] == M_LOCK);
                end
            end
            default: begin
                if (comma && !bnd) begin
                    m_bad[i]++;
                    if (m_bad[i] >= lossn[i]) begin
                        m_mode[i] = M_HUNT;
                        m_bad[i]  = 0;
                        m_good[i] = 0;
                    end
                end else if (bnd) begin
                    if (comma) m_bad[i] = 0;
                    push(i, m_hist[i], comma, 1'b1);
                end
            end
        endcase
    endtask

    task automatic mon(int i, logic v, logic [9:0] d, logic c, logic l);
        exp_t e;
        bit   empty;
        if (v) begin
            empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                chk($sformatf("dut%0d_unexpected_valid", i), 1, 0);
            end else begin
                e = (i == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("dut%0d_data", i), int'(d), int'(e.d));
                chk($sformatf("dut%0d_comma", i), int'(c), int'(e.c));
                chk($sformatf("dut%0d_locked_at_valid", i), int'(l), int'(e.l));
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            mon(0, u_if0.valid_o, u_if0.data_o, u_if0.comma_o, u_if0.locked_o);
            mon(1, u_if1.valid_o, u_if1.data_o, u_if1.comma_o, u_if1.locked_o);
        end
    end

    task automatic step(bit b, bit v, bit en);
        @(negedge clk);
        u_if0.bit_i = b; u_if0.bit_valid_i = v;
        u_if1.bit_i = b; u_if1.bit_valid_i = v;
        enable = en;
        for (int i = 0; i < 2; i++) begin
            if (!en)    model_disable(i);
            else if (v) model_bit(i, b);
        end
        @(posedge clk);
        #1;
        chk("dut0_locked", int'(u_if0.locked_o), int'(m_mode[0] == M_LOCK));
        chk("dut1_locked", int'(u_if1.locked_o), int'(m_mode[1] == M_LOCK));
        if (!en) begin
            chk("dut0_valid_after_disable", int'(u_if0.valid_o), 0);
            chk("dut1_valid_after_disable", int'(u_if1.valid_o), 0);
        end
    endtask

    task automatic send_bit(bit b);
        if (gap_mode) begin
            step(1'($urandom), 1'b0, 1'b1);
            repeat ($urandom_range(0, 5)) step(1'($urandom), 1'b0, 1'b1);
        end
        step(b, 1'b1, 1'b1);
    endtask

    task automatic send_sym(int s);
        logic [9:0] v;
        v = s[9:0];
        for (int k = 9; k >= 0; k--) send_bit(v[k]);
    endtask

    task automatic send_comma();
        send_sym(kpol ? K_POS : K_NEG);
        kpol = ~kpol;
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_dut0_data"},   int'(u_if0.data_o), 0);
        chk({tag, "_dut0_valid"},  int'(u_if0.valid_o), 0);
        chk({tag, "_dut0_comma"},  int'(u_if0.comma_o), 0);
        chk({tag, "_dut0_locked"}, int'(u_if0.locked_o), 0);
        chk({tag, "_dut1_data"},   int'(u_if1.data_o), 0);
        chk({tag, "_dut1_valid"},  int'(u_if1.valid_o), 0);
        chk({tag, "_dut1_comma"},  int'(u_if1.comma_o), 0);
        chk({tag, "_dut1_locked"}, int'(u_if1.locked_o), 0);
    endtask

    task automatic basic_sequence();
        kpol = 1'b0;
        for (int k = 0; k < 7; k++) send_bit(1'($urandom));
        send_sym(K_NEG);
        send_sym(K_POS);
        send_sym(K_NEG);
        send_sym(D21_5);
        kpol = 1'b1;
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic async_reset(string tag);
        step(1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        u_if0.bit_i = 1'b0; u_if0.bit_valid_i = 1'b0;
        u_if1.bit_i = 1'b0; u_if1.bit_valid_i = 1'b0;
        model_reset();
        #1;
        check_zero("reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        enable  = 1'b1;

        // Basic lock sequence.
        basic_sequence();
        chk("t1_dut0_locked", int'(u_if0.locked_o), 1);
        send_sym(D21_5);
        send_comma();

        // Bit slip while locked, then commas at the new offset.
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        repeat (5) send_comma();
        send_sym(D21_5);
        chk("t2_dut0_relocked", int'(u_if0.locked_o), 1);

        // Same lock sequence with qualifier gaps.
        async_reset("t3_reset");
        gap_mode = 1'b1;
        basic_sequence();
        gap_mode = 1'b0;

        // Enable drop mid-symbol while locked.
        for (int k = 0; k < 4; k++) send_bit(1'(D21_5 >> (9 - k)));
        step(1'b1, 1'b1, 1'b0);
        chk("t4_dut0_unlocked", int'(u_if0.locked_o), 0);
        for (int k = 4; k < 10; k++) send_bit(1'(D21_5 >> (9 - k)));
        repeat (4) send_comma();
        chk("t4_dut0_relocked", int'(u_if0.locked_o), 1);

        // Asynchronous reset mid-symbol while locked.
        for (int k = 0; k < 5; k++) send_bit(1'($urandom));
        async_reset("t5_reset");
        basic_sequence();

        // Random stream with slips, gaps and occasional enable drops.
        for (int s = 0; s < 160; s++) begin
            int r;
            r = $urandom_range(0, 9);
            gap_mode = ($urandom_range(0, 3) == 0);
            if (r < 4)       send_comma();
            else if (r == 8) repeat ($urandom_range(1, 4)) send_bit(1'($urandom));
            else if (r == 9 && $urandom_range(0, 3) == 0) step(1'($urandom), 1'b1, 1'b0);
            else             send_sym(int'($urandom_range(0, 1023)));
        end
        gap_mode = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b1);

        chk("end_dut0_queue_empty", q0.size(), 0);
        chk("end_dut1_queue_empty", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
